// File: rtl/button_gesture_decoder_pkg.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder_pkg
//   Shared definitions for the button gesture decoder and its consumers:
//   FSM state encoding, gesture event codes for downstream logic, and the
//   helper that turns a clock frequency into clocks per millisecond.
//   No ports (package).
// -----------------------------------------------------------------------------
package button_gesture_decoder_pkg;

   // 3-bit FSM state encoding.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESS1    = 3'd1,
      ST_WAIT2     = 3'd2,
      ST_PRESS2    = 3'd3,
      ST_LONG_HELD = 3'd4
   } state_t;

   // Gesture event codes for consumers that prefer an encoded event
   // (e.g. a UART command mapper) over the individual pulse outputs.
   typedef enum logic [2:0] {
      EV_NONE   = 3'd0,
      EV_SHORT  = 3'd1,
      EV_DOUBLE = 3'd2,
      EV_LONG   = 3'd3,
      EV_REPEAT = 3'd4
   } gesture_t;

   localparam int unsigned MS_PER_SEC = 1000;

   // Number of input clocks in one millisecond.
   function automatic int unsigned clk_per_ms(input int unsigned clk_hz);
      return clk_hz / MS_PER_SEC;
   endfunction

endpackage : button_gesture_decoder_pkg

// File: rtl/button_gesture_decoder_ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
//   Millisecond prescaler. Counts 0..CLK_HZ/1000-1 and raises tick for the one
//   cycle spent at terminal count. A synchronous clear restarts the count so
//   the owner can align millisecond boundaries to its own events.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous reset, active-high
//   clr   in  synchronous clear of the prescaler
//   tick  out one-cycle pulse once per millisecond
// -----------------------------------------------------------------------------
module ms_tick_gen
   import button_gesture_decoder_pkg::*;
#(
   parameter int unsigned CLK_HZ = 12_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned DIV = clk_per_ms(CLK_HZ);
   localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tick;

   assign w_tick = (r_cnt == LAST);
   assign tick   = w_tick;

   // NOTE: state registers use non-blocking (<=) assignments and an
   // asynchronous reset in the sensitivity list, so every flop updates from
   // the pre-edge values and reset does not wait for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : ms_tick_gen

// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
//   Classifies debounced button edges into short press, double press and long
//   press gestures, with an auto-repeat pulse while the button stays held after
//   a long press. All durations are measured in milliseconds from an internal
//   1 ms tick whose phase restarts on every state change.
// Ports
//   clk           in  system clock
//   rst           in  asynchronous reset, active-high
//   btn_rising    in  one-cycle pulse: debounced press
//   btn_falling   in  one-cycle pulse: debounced release
//   short_press   out one-cycle pulse: single click recognised
//   double_press  out one-cycle pulse: double click recognised
//   long_press    out one-cycle pulse: hold reached LONG_MS
//   hold_repeat   out one-cycle pulse every REPEAT_MS while held after long_press
//   busy          out level: a gesture is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module button_gesture_decoder
   import button_gesture_decoder_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 12_000_000,
   parameter int unsigned LONG_MS   = 800,
   parameter int unsigned DOUBLE_MS = 300,
   parameter int unsigned REPEAT_MS = 200,
   parameter int          TMR_W     = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_rising,
   input  logic btn_falling,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic hold_repeat,
   output logic busy
);

   localparam logic [TMR_W-1:0] LONG_T   = TMR_W'(LONG_MS);
   localparam logic [TMR_W-1:0] DOUBLE_T = TMR_W'(DOUBLE_MS);
   localparam logic [TMR_W-1:0] REPEAT_T = TMR_W'(REPEAT_MS);

   state_t           r_state;
   state_t           w_state_nx;
   logic [TMR_W-1:0] r_timer;
   logic [TMR_W-1:0] w_timer_nx;
   logic             w_tick;
   logic             w_clr;
   logic             w_restart;
   logic             w_rise;
   logic             w_fall;
   logic             w_short_nx;
   logic             w_double_nx;
   logic             w_long_nx;
   logic             w_repeat_nx;
   logic             r_short;
   logic             r_double;
   logic             r_long;
   logic             r_repeat;

   // Coincident edges cancel: the debouncer cannot have seen both a press and
   // a release in one cycle, so treat it as noise.
   assign w_rise = btn_rising  & ~btn_falling;
   assign w_fall = btn_falling & ~btn_rising;

   ms_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .tick (w_tick)
   );

   // Timeouts look at the value the timer is about to take, so a threshold is
   // acted on at the same edge as the tick that reaches it. This makes every
   // duration an exact multiple of 1 ms measured from the state entry edge.
   assign w_timer_nx = (w_tick && (r_timer != '1)) ? r_timer + 1'b1 : r_timer;

   // Prescaler and timer restart on any state change and on each repeat.
   assign w_clr = (w_state_nx != r_state) || w_restart;

   // NOTE: every signal written here gets a default before the case, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nx  = r_state;
      w_restart   = 1'b0;
      w_short_nx  = 1'b0;
      w_double_nx = 1'b0;
      w_long_nx   = 1'b0;
      w_repeat_nx = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nx = ST_PRESS1;
            end
         end
         ST_PRESS1: begin
            if (w_fall) begin
               w_state_nx = ST_WAIT2;
            end else if (w_timer_nx >= LONG_T) begin
               w_state_nx = ST_LONG_HELD;
               w_long_nx  = 1'b1;
            end
         end
         ST_WAIT2: begin
            // Edge beats timeout: a press landing on the DOUBLE_MS tick
            // still counts as the second click.
            if (w_rise) begin
               w_state_nx = ST_PRESS2;
            end else if (w_timer_nx >= DOUBLE_T) begin
               w_state_nx = ST_IDLE;
               w_short_nx = 1'b1;
            end
         end
         ST_PRESS2: begin
            if (w_fall) begin
               w_state_nx  = ST_IDLE;
               w_double_nx = 1'b1;
            end else if (w_timer_nx >= LONG_T) begin
               // The first click is reported late, alongside the long hold
               // of the second press.
               w_state_nx = ST_LONG_HELD;
               w_short_nx = 1'b1;
               w_long_nx  = 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (w_fall) begin
               w_state_nx = ST_IDLE;
            end else if (w_timer_nx >= REPEAT_T) begin
               w_repeat_nx = 1'b1;
               w_restart   = 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_timer  <= '0;
         r_short  <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_repeat <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_timer  <= w_clr ? '0 : w_timer_nx;
         r_short  <= w_short_nx;
         r_double <= w_double_nx;
         r_long   <= w_long_nx;
         r_repeat <= w_repeat_nx;
      end
   end

   assign short_press  = r_short;
   assign double_press = r_double;
   assign long_press   = r_long;
   assign hold_repeat  = r_repeat;
   assign busy         = (r_state != ST_IDLE);

endmodule : button_gesture_decoder
